fractal_stream_sequencer: RTL

Raster sequencer that drives the `fractal_colorizer` pipeline and the fractal iteration core ahead of it. It produces the pixel coordinates and the `frame_start` / `line_end` / `data_enable` sideband for each frame. It owns the colorizer `mode`, changing it only on frame boundaries, either from a software request or by auto-cycling through palettes. It honours a downstream `ready` stall so the stream can be paused without corrupting frame structure.

---
 rtl/fractal_pkg.sv | 17 +
 rtl/fractal_xy_counter.sv | 46 ++++
 rtl/fractal_stream_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/fractal_pkg.sv
// Shared types for the fractal stream path: palette mode, sequencer states, coordinate width.
// Combinational helpers only; no latency or backpressure of their own.
package fractal_pkg;
  localparam int COORD_W = 11;

  typedef logic [3:0] mode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } seq_state_t;

  function automatic mode_t next_mode(input mode_t m, input int num_modes);
    return (int'(m) == num_modes - 1) ? mode_t'(0) : m + mode_t'(1);
  endfunction
endpackage

// File: rtl/fractal_xy_counter.sv
// Raster x/y counter with registered end-of-line/end-of-frame flags; 1-cycle update per advance.
// Holds position whenever advance is low, which is how downstream stalls freeze the raster.
module fractal_xy_counter
  import fractal_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_in_line,
  output logic               last_in_frame
);
  logic [COORD_W-1:0] nx, ny;

  always_comb begin
    nx = x;
    ny = y;
    if (advance) begin
      if (last_in_line) begin
        nx = '0;
        ny = last_in_frame ? '0 : y + COORD_W'(1);
      end else begin
        nx = x + COORD_W'(1);
      end
    end
  end

  // Flags are computed from the next position so they line up with the registered x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      x             <= '0;
      y             <= '0;
      last_in_line  <= 1'b0;
      last_in_frame <= 1'b0;
    end else begin
      x             <= nx;
      y             <= ny;
      last_in_line  <= (nx == COORD_W'(WIDTH - 1));
      last_in_frame <= (nx == COORD_W'(WIDTH - 1)) && (ny == COORD_W'(HEIGHT - 1));
    end
  end
endmodule

// File: rtl/fractal_stream_sequencer.sv
// Raster sequencer for the colorizer: emits x/y beats with sideband, switches mode only between frames; outputs registered, first beat 1 cycle after enable.
// A beat holds while ready is low; dropping enable drains the current frame before going idle.
module fractal_stream_sequencer
  import fractal_pkg::*;
#(
  parameter int WIDTH            = 1920,
  parameter int HEIGHT           = 1080,
  parameter int NUM_MODES        = 8,
  parameter int MODE_HOLD_FRAMES = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               auto_cycle,
  input  logic [3:0]         mode_req,
  input  logic               mode_req_valid,
  input  logic               ready,
  output mode_t              mode,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_start,
  output logic               line_end,
  output logic               data_enable,
  output logic               busy
);
  localparam int HOLD_W = $clog2(MODE_HOLD_FRAMES) + 1;

  seq_state_t        state;
  mode_t             pend;
  logic              pend_vld;
  logic [HOLD_W-1:0] hold;
  logic              xfer, last_in_frame, frame_done, start_frame, req_ok;

  assign xfer        = data_enable & ready;
  assign frame_done  = xfer & last_in_frame;
  assign start_frame = enable & ((state == IDLE) | frame_done);
  assign req_ok      = mode_req_valid && (int'(mode_req) < NUM_MODES);

  fractal_xy_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_xy (
    .clk          (clk),
    .reset        (reset),
    .advance      (xfer),
    .x            (x),
    .y            (y),
    .last_in_line (line_end),
    .last_in_frame(last_in_frame)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode        <= '0;
      pend        <= '0;
      pend_vld    <= 1'b0;
      hold        <= '0;
      frame_start <= 1'b0;
      data_enable <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= RUN;
            data_enable <= 1'b1;
            busy        <= 1'b1;
            frame_start <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (frame_done) begin
            state       <= enable ? RUN : IDLE;
            data_enable <= enable;
            busy        <= enable;
            frame_start <= enable;
          end else begin
            if (xfer) frame_start <= 1'b0;
            if (!enable) state <= DRAIN;
          end
        end
        default: state <= IDLE;
      endcase

      if (start_frame) begin
        if (pend_vld) begin
          mode     <= pend;
          pend_vld <= 1'b0;
          hold     <= '0;
        end else if (auto_cycle && hold == HOLD_W'(MODE_HOLD_FRAMES - 1)) begin
          mode <= next_mode(mode, NUM_MODES);
          hold <= '0;
        end else begin
          hold <= auto_cycle ? hold + HOLD_W'(1) : '0;
        end
      end

      // Placed after the boundary update so a same-cycle request survives as pending.
      if (req_ok) begin
        pend     <= mode_req;
        pend_vld <= 1'b1;
      end
    end
  end
endmodule
